traffic_ctrl_multi: RTL and testbench



---
 rtl/traffic_ctrl_multi.sv | 201 ++++++++++++++++++++
 tb/tb_traffic_ctrl_multi.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_multi.sv
// ----------------------------------------------------------------------------
// traffic_ctrl_multi
//
// Multi-approach Moore traffic-light controller. Each approach in turn goes
// through GREEN -> YELLOW -> ALL_RED. Green is handed out round-robin and is
// given to approaches with demand where there is any. All timing counts
// cycles of the external enable 'tick'. On a board 'tick' is a 1 Hz strobe.
// In simulation 'tick' can be held high.
//
// Ports:
//   clk         clock
//   reset_n     asynchronous active-low reset
//   tick        timing enable; state and timer move only when tick=1
//   sensor      per-direction demand, already synchronised to clk
//   lights      lights[3d+2:3d] = {Red,Yellow,Green} for direction d
//   active_dir  direction that owns the current phase
//   phase       00 GREEN, 01 YELLOW, 10 ALL_RED
//
// Optional feature, macro TRAFFIC_PREEMPT_EN:
//   This macro adds the inputs preempt_req and preempt_dir, for emergency
//   vehicle preemption.
//   - A green on any other direction is cut short on the next tick.
//   - The next ALL_RED exit selects preempt_dir.
//   - The preempted direction then holds green for as long as the request
//     stays high.
//   - A preempt_dir outside 0..NUM_DIRS-1 is ignored.
// ----------------------------------------------------------------------------
module traffic_ctrl_multi #(
    parameter int NUM_DIRS     = 4,
    parameter int MIN_GREEN    = 3,
    parameter int MAX_GREEN    = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    localparam int DIR_W       = (NUM_DIRS > 2) ? $clog2(NUM_DIRS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic [NUM_DIRS-1:0]   sensor,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                  preempt_req,
    input  logic [DIR_W-1:0]      preempt_dir,
`endif
    output logic [3*NUM_DIRS-1:0] lights,
    output logic [DIR_W-1:0]      active_dir,
    output logic [1:0]            phase
);

    localparam int TMAX_GY = (MAX_GREEN > YELLOW_TICKS) ? MAX_GREEN : YELLOW_TICKS;
    localparam int TMAX    = (TMAX_GY > ALLRED_TICKS) ? TMAX_GY : ALLRED_TICKS;
    localparam int TW      = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_t;

    phase_t             phase_q, phase_nx;
    logic [DIR_W-1:0]   dir_q, dir_nx;
    logic [TW-1:0]      timer_q, timer_nx;
    logic [TW:0]        elapsed;
    logic               other_demand;
    logic               go_yellow;

    // Saturating increment. The timer value never passes lim.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t,
                                              input logic [TW-1:0] lim);
        return (t >= lim) ? t : t + TW'(1);
    endfunction

    // Round-robin search for the next green.
    // The search starts at cur+1 and tests cur itself last.
    // If no direction has demand, the result is cur+1.
    function automatic logic [DIR_W-1:0] pick_next(input logic [DIR_W-1:0]    cur,
                                                   input logic [NUM_DIRS-1:0] req);
        logic [DIR_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = DIR_W'((int'(cur) + 1) % NUM_DIRS);
        found = 1'b0;
        for (int k = 1; k <= NUM_DIRS; k++) begin
            idx = (int'(cur) + k) % NUM_DIRS;
            if (!found && req[idx]) begin
                sel   = DIR_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign elapsed = {1'b0, timer_q} + (TW+1)'(1);

    always_comb begin
        other_demand = 1'b0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            if (d != int'(dir_q))
                other_demand = other_demand | sensor[d];
        end
    end

`ifdef TRAFFIC_PREEMPT_EN
    logic pre_valid;
    assign pre_valid = preempt_req && (int'(preempt_dir) < NUM_DIRS);

    always_comb begin
        go_yellow = 1'b0;
        if (pre_valid) begin
            // A valid request freezes its own green.
            // The request cuts any other green at once.
            go_yellow = (preempt_dir != dir_q);
        end else if (other_demand) begin
            go_yellow = (elapsed >= (TW+1)'(MAX_GREEN)) ||
                        ((elapsed >= (TW+1)'(MIN_GREEN)) && !sensor[dir_q]);
        end
    end
`else
    always_comb begin
        go_yellow = 1'b0;
        if (other_demand) begin
            go_yellow = (elapsed >= (TW+1)'(MAX_GREEN)) ||
                        ((elapsed >= (TW+1)'(MIN_GREEN)) && !sensor[dir_q]);
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_ALLRED;
            dir_q   <= DIR_W'(NUM_DIRS - 1);
            timer_q <= '0;
        end else begin
            phase_q <= phase_nx;
            dir_q   <= dir_nx;
            timer_q <= timer_nx;
        end
    end

    // Next-state logic. Only tick cycles can change anything.
    always_comb begin
        phase_nx = phase_q;
        dir_nx   = dir_q;
        timer_nx = timer_q;
        if (tick) begin
            case (phase_q)
                PH_GREEN: begin
                    if (go_yellow) begin
                        phase_nx = PH_YELLOW;
                        timer_nx = '0;
                    end else begin
                        timer_nx = sat_inc(timer_q, TW'(MAX_GREEN));
                    end
                end
                PH_YELLOW: begin
                    if (elapsed == (TW+1)'(YELLOW_TICKS)) begin
                        phase_nx = PH_ALLRED;
                        timer_nx = '0;
                    end else begin
                        timer_nx = sat_inc(timer_q, TW'(TMAX));
                    end
                end
                PH_ALLRED: begin
                    if (elapsed == (TW+1)'(ALLRED_TICKS)) begin
                        phase_nx = PH_GREEN;
                        timer_nx = '0;
`ifdef TRAFFIC_PREEMPT_EN
                        dir_nx   = pre_valid ? preempt_dir : pick_next(dir_q, sensor);
`else
                        dir_nx   = pick_next(dir_q, sensor);
`endif
                    end else begin
                        timer_nx = sat_inc(timer_q, TW'(TMAX));
                    end
                end
                default: begin
                    phase_nx = PH_ALLRED;
                    timer_nx = '0;
                end
            endcase
        end
    end

    // Moore outputs, decoded from the registered state only
    always_comb begin
        lights = '0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            lights[3*d +: 3] = 3'b100;
            if (d == int'(dir_q)) begin
                if (phase_q == PH_GREEN)
                    lights[3*d +: 3] = 3'b001;
                else if (phase_q == PH_YELLOW)
                    lights[3*d +: 3] = 3'b010;
            end
        end
    end

    assign active_dir = dir_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
module tb_traffic_ctrl_multi;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick;
    logic [3:0]  sensor;
    logic [11:0] lights;
    logic [1:0]  active_dir;
    logic [1:0]  phase;
`ifdef TRAFFIC_PREEMPT_EN
    logic        preempt_req;
    logic [1:0]  preempt_dir;
`endif

    int checks   = 0;
    int failures = 0;
    bit div4     = 1'b0;
    int tcnt     = 0;

    traffic_ctrl_multi dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .sensor     (sensor),
`ifdef TRAFFIC_PREEMPT_EN
        .preempt_req(preempt_req),
        .preempt_dir(preempt_dir),
`endif
        .lights     (lights),
        .active_dir (active_dir),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Sample 1 time unit after the edge. Then drive tick for the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (div4) begin
            tick = ((tcnt % 4) == 3);
            tcnt++;
        end else begin
            tick = 1'b1;
        end
    endtask

    // Check n consecutive samples against one expected output set, then advance.
    task automatic run(input string tag, input logic [11:0] l, input logic [1:0] ph,
                       input logic [1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_lights"}, 32'(lights), 32'(l));
            check({tag, "_phase"}, 32'(phase), 32'(ph));
            check({tag, "_dir"}, 32'(active_dir), 32'(d));
            cyc();
        end
    endtask

    // Reset, then release. This ends at the sample where dir0 has just turned green.
    task automatic do_reset();
        sensor  = 4'b0000;
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        reset_n = 1'b0;
        tick    = 1'b1;
        sensor  = 4'b0000;
`ifdef TRAFFIC_PREEMPT_EN
        preempt_req = 1'b0;
        preempt_dir = 2'd0;
`endif
        // Scenario 1: reset state, release, dir0 green held with no demand
        cyc();
        cyc();
        check("rst_lights", 32'(lights), 32'h924);
        check("rst_phase", 32'(phase), 32'h2);
        check("rst_dir", 32'(active_dir), 32'h3);
        reset_n = 1'b1;
        #2;
        check("post_rst_lights", 32'(lights), 32'h924);
        cyc();
        run("idle_green", 12'h921, 2'b00, 2'd0, 100);

        // Scenario 2: minimum green, then hand over to dir1
        do_reset();
        sensor = 4'b0010;
        run("s2_green", 12'h921, 2'b00, 2'd0, 3);
        run("s2_yellow", 12'h922, 2'b01, 2'd0, 2);
        run("s2_allred", 12'h924, 2'b10, 2'd0, 1);
        run("s2_dir1", 12'h90C, 2'b00, 2'd1, 1);

        // Scenario 3: own demand keeps green to MAX_GREEN, and dir1 is skipped
        do_reset();
        sensor = 4'b0101;
        run("s3_green", 12'h921, 2'b00, 2'd0, 8);
        run("s3_yellow", 12'h922, 2'b01, 2'd0, 2);
        run("s3_allred", 12'h924, 2'b10, 2'd0, 1);
        run("s3_dir2", 12'h864, 2'b00, 2'd2, 1);

        // Scenario 4: tick one cycle in four stretches every phase by four
        do_reset();
        sensor = 4'b0010;
        div4   = 1'b1;
        tcnt   = 1;
        tick   = 1'b0;
        run("s4_green", 12'h921, 2'b00, 2'd0, 12);
        run("s4_yellow", 12'h922, 2'b01, 2'd0, 8);
        run("s4_allred", 12'h924, 2'b10, 2'd0, 4);
        run("s4_dir1", 12'h90C, 2'b00, 2'd1, 1);
        div4 = 1'b0;
        tick = 1'b1;

        // Scenario 5: asynchronous reset mid-yellow, then the power-up sequence again
        do_reset();
        sensor = 4'b0010;
        run("s5_green", 12'h921, 2'b00, 2'd0, 3);
        run("s5_yellow", 12'h922, 2'b01, 2'd0, 1);
        reset_n = 1'b0;
        sensor  = 4'b0000;
        #1;
        check("s5_async_lights", 32'(lights), 32'h924);
        check("s5_async_phase", 32'(phase), 32'h2);
        check("s5_async_dir", 32'(active_dir), 32'h3);
        cyc();
        reset_n = 1'b1;
        #2;
        check("s5_post_rst_lights", 32'(lights), 32'h924);
        cyc();
        run("s5_restart", 12'h921, 2'b00, 2'd0, 5);

`ifdef TRAFFIC_PREEMPT_EN
        // Preemption cuts dir0 short, then dir3 holds while requested
        do_reset();
        sensor = 4'b0011;
        run("pe_green", 12'h921, 2'b00, 2'd0, 1);
        preempt_req = 1'b1;
        preempt_dir = 2'd3;
        run("pe_green2", 12'h921, 2'b00, 2'd0, 1);
        run("pe_yellow", 12'h922, 2'b01, 2'd0, 2);
        run("pe_allred", 12'h924, 2'b10, 2'd0, 1);
        run("pe_dir3", 12'h324, 2'b00, 2'd3, 12);
        preempt_req = 1'b0;
        run("pe_release", 12'h324, 2'b00, 2'd3, 1);
        run("pe_dir3_yellow", 12'h524, 2'b01, 2'd3, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
